// File: rtl/pattern_pkg.sv
// Shared types for the video test-pattern generator: pattern modes, an RGB
// triple and the colour-bar lookup.
package pattern_pkg;

  typedef enum logic [2:0] {
    MODE_BARS  = 3'd0,
    MODE_RAMP  = 3'd1,
    MODE_CHECK = 3'd2,
    MODE_MBAR  = 3'd3
  } mode_e;

  // Widest colour component any instance may use; callers truncate to CW.
  localparam int RGB_MAXW = 16;

  typedef struct packed {
    logic [RGB_MAXW-1:0] r;
    logic [RGB_MAXW-1:0] g;
    logic [RGB_MAXW-1:0] b;
  } rgb_t;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t bar_colour(input logic [2:0] idx, input logic [RGB_MAXW-1:0] lvl);
    logic [2:0] m;
    rgb_t       c;
    case (idx)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    c.r = m[2] ? lvl : '0;
    c.g = m[1] ? lvl : '0;
    c.b = m[0] ? lvl : '0;
    return c;
  endfunction

endpackage

// File: rtl/pattern_pos_track.sv
// Stage 1: follows de/vs edges to track the pixel position, bar index and
// ramp accumulator, and registers them for the colour stage.
module pattern_pos_track #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int CW       = 8,
  parameter int FRAC     = 16,
  parameter int XW       = $clog2(H_ACTIVE + 1),
  parameter int YW       = $clog2(V_ACTIVE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          de_i,
  input  logic          vs_i,
  output logic          vs_rise,
  output logic          s1_de,
  output logic [XW-1:0] s1_x,
  output logic [YW-1:0] s1_y,
  output logic [2:0]    s1_bar,
  output logic [CW:0]   s1_ramp
);

  localparam int BW  = H_ACTIVE / 8;
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;
  localparam int AW  = CW + FRAC + 1;
  localparam logic [63:0] MAXV     = (64'd1 << CW) - 64'd1;
  localparam logic [63:0] RAMP_INC = ((MAXV << FRAC) + 64'(H_ACTIVE - 2)) / 64'(H_ACTIVE - 1);
  localparam logic [AW-1:0] INC    = AW'(RAMP_INC);

  logic           de_q, vs_q;
  logic [XW-1:0]  x_cnt;
  logic [YW-1:0]  y_cnt;
  logic [BCW-1:0] bw_cnt;
  logic [2:0]     bar_idx;
  logic [AW-1:0]  acc;
  logic           de_fall;

  assign vs_rise = vs_i & ~vs_q;
  assign de_fall = de_q & ~de_i;

  // NOTE: every register here uses <= so all stage-1 values are taken from
  // the same pre-edge state, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
      bw_cnt  <= '0;
      bar_idx <= '0;
      acc     <= '0;
      s1_de   <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_bar  <= '0;
      s1_ramp <= '0;
    end else begin
      de_q    <= de_i;
      vs_q    <= vs_i;
      s1_de   <= de_i;
      s1_x    <= x_cnt;
      s1_y    <= y_cnt;
      s1_bar  <= bar_idx;
      s1_ramp <= acc[AW-1:FRAC];

      // Frame start takes priority over a coincident line end.
      if (vs_rise || de_fall) begin
        x_cnt   <= '0;
        bw_cnt  <= '0;
        bar_idx <= '0;
        acc     <= '0;
        if (vs_rise)
          y_cnt <= '0;
        else if (y_cnt != YW'(V_ACTIVE - 1))
          y_cnt <= y_cnt + YW'(1);
      end else if (de_i && x_cnt != XW'(H_ACTIVE)) begin
        x_cnt <= x_cnt + XW'(1);
        acc   <= acc + INC;
        if (bw_cnt == BCW'(BW - 1)) begin
          bw_cnt  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bw_cnt <= bw_cnt + BCW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Registered video test-pattern generator: bars, ramp, checker and moving bar,
// selected per frame, with de/hs/vs re-timed to the 2-cycle pixel pipeline.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080,
  parameter int CW        = 8,
  parameter int CHK_LOG2  = 6,
  parameter int MBAR_W    = 64,
  parameter int MBAR_STEP = 8,
  parameter int FRAC      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          de_i,
  input  logic          hs_i,
  input  logic          vs_i,
  input  logic [2:0]    mode_i,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic [2:0]    mode_o
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0] MAXC = '1;
  localparam logic [CW-1:0] L75  = CW'(3 << (CW - 2));

  logic          vs_rise, s1_de;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic [2:0]    s1_bar;
  logic [CW:0]   s1_ramp;

  pattern_pos_track #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CW       (CW),
    .FRAC     (FRAC),
    .XW       (XW),
    .YW       (YW)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .de_i    (de_i),
    .vs_i    (vs_i),
    .vs_rise (vs_rise),
    .s1_de   (s1_de),
    .s1_x    (s1_x),
    .s1_y    (s1_y),
    .s1_bar  (s1_bar),
    .s1_ramp (s1_ramp)
  );

  logic [2:0]    mode_q;
  logic [XW-1:0] pos;
  logic [XW:0]   pos_nxt;
  logic          hs_d1, vs_d1;

  assign pos_nxt = {1'b0, pos} + (XW + 1)'(MBAR_STEP);
  assign mode_o  = mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
      pos    <= '0;
    end else if (vs_rise) begin
      mode_q <= mode_i;
      pos    <= (pos_nxt >= (XW + 1)'(H_ACTIVE)) ? '0 : pos_nxt[XW-1:0];
    end
  end

  rgb_t          bar_c;
  logic [31:0]   xw, yw, pw;
  logic          chk_on, in_bar;
  logic [CW-1:0] r_n, g_n, b_n;

  // NOTE: every signal driven here gets a default before the case, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    bar_c  = bar_colour(s1_bar, RGB_MAXW'(L75));
    xw     = 32'(s1_x);
    yw     = 32'(s1_y);
    pw     = 32'(pos);
    chk_on = (((xw ^ yw) >> CHK_LOG2) & 32'd1) != 32'd0;
    in_bar = (xw >= pw) && (xw < pw + 32'(MBAR_W));
    r_n    = '0;
    g_n    = '0;
    b_n    = '0;
    if (s1_de && s1_x < XW'(H_ACTIVE)) begin
      case (mode_q)
        MODE_BARS: begin
          r_n = CW'(bar_c.r);
          g_n = CW'(bar_c.g);
          b_n = CW'(bar_c.b);
        end
        MODE_RAMP: begin
          r_n = s1_ramp[CW] ? MAXC : s1_ramp[CW-1:0];
          g_n = r_n;
          b_n = r_n;
        end
        MODE_CHECK: if (chk_on) begin
          r_n = MAXC;
          g_n = MAXC;
          b_n = MAXC;
        end
        MODE_MBAR: if (in_bar) begin
          r_n = MAXC;
          g_n = MAXC;
          b_n = MAXC;
        end
        default: ;
      endcase
    end
  end

  // Stage 2: colour output and the matching sync delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d1 <= 1'b0;
      vs_d1 <= 1'b0;
      de_o  <= 1'b0;
      hs_o  <= 1'b0;
      vs_o  <= 1'b0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      hs_d1 <= hs_i;
      vs_d1 <= vs_i;
      de_o  <= s1_de;
      hs_o  <= hs_d1;
      vs_o  <= vs_d1;
      r     <= r_n;
      g     <= g_n;
      b     <= b_n;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Randomised-timing bench for pattern_gen with a per-pixel reference model
// computed from pixel coordinates and frame state.
module tb_pattern_gen;

  localparam int H = 128, V = 8, CW = 8, CHK = 2, MW = 16, STEP = 8, FRAC = 16;
  localparam int MAXV = 255, L75 = 192, BW = H / 8;
  localparam longint INC = (longint'(MAXV) * (longint'(1) << FRAC) + H - 2) / (H - 1);
  localparam logic [2:0] BAR_MASK [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};

  logic          clk = 1'b0, rst = 1'b1;
  logic          de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [2:0]    mode_i = 3'd0;
  logic          de_o, hs_o, vs_o;
  logic [CW-1:0] r, g, b;
  logic [2:0]    mode_o;

  pattern_gen #(
    .H_ACTIVE (H), .V_ACTIVE (V), .CW (CW), .CHK_LOG2 (CHK),
    .MBAR_W (MW), .MBAR_STEP (STEP), .FRAC (FRAC)
  ) dut (
    .clk (clk), .rst (rst), .de_i (de_i), .hs_i (hs_i), .vs_i (vs_i),
    .mode_i (mode_i), .de_o (de_o), .hs_o (hs_o), .vs_o (vs_o),
    .r (r), .g (g), .b (b), .mode_o (mode_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  sync;
    logic [23:0] rgb;
    bit          aligned;
    int          mode, x, y, pos;
  } exp_t;

  exp_t q[$];
  int   mx, my, mmode, mpos;
  bit   pde, pvs, aligned;
  logic [7:0] last_r;

  function automatic logic [23:0] ref_rgb(input int mode, input int x, input int y, input int pos);
    logic [2:0] m;
    longint     v;
    if (x >= H) return 24'h0;
    case (mode)
      0: begin
        m = BAR_MASK[x / BW];
        return {m[2] ? 8'(L75) : 8'h0, m[1] ? 8'(L75) : 8'h0, m[0] ? 8'(L75) : 8'h0};
      end
      1: begin
        v = (longint'(x) * INC) >> FRAC;
        if (v > MAXV) v = MAXV;
        return {3{8'(v)}};
      end
      2: return (((x >> CHK) ^ (y >> CHK)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
      3: return (x >= pos && x < pos + MW) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  task automatic spot(input exp_t e);
    logic [23:0] px;
    px = {r, g, b};
    if (e.mode == 0 && e.y == 0) begin
      if (e.x == 0)          check("bars_white", px, 24'hC0C0C0);
      if (e.x == BW)         check("bars_yellow", px, 24'hC0C000);
      if (e.x == 7 * BW - 1) check("bars_blue", px, 24'h0000C0);
      if (e.x == 7 * BW)     check("bars_black", px, 24'h000000);
    end
    if (e.mode == 1) begin
      if (e.x == 0)     check("ramp_x0", px, 24'h000000);
      if (e.x == H / 2) check("ramp_mid", px, 24'h808080);
      if (e.x == H - 1) check("ramp_end", px, 24'hFFFFFF);
      if (e.x > 0 && e.x < H) check("ramp_mono", 32'(r >= last_r), 32'd1);
      last_r = r;
    end
    if (e.mode == 2) begin
      if (e.x == 0 && e.y == 0)                 check("chk_00", px, 24'h000000);
      if (e.x == (1 << CHK) && e.y == 0)        check("chk_x1", px, 24'hFFFFFF);
      if (e.x == (1 << CHK) && e.y == (1 << CHK)) check("chk_xy", px, 24'h000000);
    end
    if (e.mode == 3 && e.pos == H - STEP) begin
      if (e.x == H - STEP) check("mbar_edge_lo", px, 24'hFFFFFF);
      if (e.x == H - 1)    check("mbar_edge_hi", px, 24'hFFFFFF);
      if (e.x == 0)        check("mbar_nowrap", px, 24'h000000);
    end
    if (e.mode == 5 && e.x == 0) check("solid5", px, 24'h000000);
  endtask

  task automatic tick(input logic de, input logic hs, input logic vs);
    exp_t e;
    @(negedge clk);
    check("mode", 32'(mode_o), 32'(mmode));
    if (q.size() == 2) begin
      e = q.pop_front();
      check("sync", 32'({de_o, hs_o, vs_o}), 32'(e.sync));
      if (e.aligned) begin
        check("rgb", 32'({r, g, b}), 32'(e.rgb));
        if (e.sync[2]) spot(e);
      end
    end
    de_i = de;
    hs_i = hs;
    vs_i = vs;
    e.sync    = {de, hs, vs};
    e.aligned = aligned;
    e.mode    = mmode;
    e.x       = mx;
    e.y       = my;
    e.pos     = mpos;
    e.rgb     = de ? ref_rgb(mmode, mx, my, mpos) : 24'h0;
    q.push_back(e);
    if (vs && !pvs) begin
      mx = 0;
      my = 0;
      mmode = int'(mode_i);
      mpos = (mpos + STEP >= H) ? 0 : mpos + STEP;
      aligned = 1'b1;
    end else if (!de && pde) begin
      mx = 0;
      if (my < V - 1) my++;
    end else if (de && mx < H) begin
      mx++;
    end
    pde = de;
    pvs = vs;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    de_i = 1'b1;
    hs_i = 1'b0;
    vs_i = 1'b0;
    mx = 0; my = 0; mmode = 0; mpos = 0;
    pde = 1'b0; pvs = 1'b0; aligned = 1'b0;
    q.delete();
    repeat (n) begin
      @(negedge clk);
      check("rst", 32'({de_o, hs_o, vs_o, mode_o, r, g, b}), 32'd0);
    end
    rst = 1'b0;
    de_i = 1'b0;
  endtask

  // One frame: two blanking lines (vs pulse at the start), then V active lines
  // with random horizontal blanking; mode_i switches to mb halfway down.
  task automatic frame(input int ma, input int mb, input int cut_line);
    mode_i = 3'(ma);
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < H + 8; c++)
        tick(1'b0, c >= 6 && c < 8, l == 0 && c < 4);
    for (int l = 0; l < V; l++) begin
      int hb = $urandom_range(4, 12);
      if (l == V / 2) mode_i = 3'(mb);
      for (int c = 0; c < H; c++) begin
        if (l == cut_line && c == H / 2) return;
        tick(1'b1, 1'b0, 1'b0);
      end
      for (int c = 0; c < hb; c++) tick(1'b0, c == 1 || c == 2, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    last_r = 8'h0;
    do_reset(3);
    frame(0, 0, -1);
    frame(0, 0, 3);
    do_reset(5);
    frame(0, 0, -1);
    frame(0, 0, -1);
    frame(1, 1, -1);
    frame(1, 1, -1);
    frame(2, 2, -1);
    frame(2, 2, -1);
    for (int f = 0; f < 18; f++) frame(3, 3, -1);
    frame(0, 2, -1);
    frame(2, 2, -1);
    frame(5, 5, -1);
    for (int f = 0; f < 4; f++) frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), -1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
